// File: rtl/idmem_port_arbiter.sv
// Two-requester arbiter in front of a single-port unified instruction/data memory.
// Fetch (IF, read-only) and load/store (D) share one pipelined access slot per cycle.
// Fixed priority with a starvation guard; responses are registered per requester.
module idmem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned D_PRIORITY   = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wd,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic D_IS_HI = (D_PRIORITY != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SW-1:0]         r_starve;
    logic [ADDR_WIDTH-1:0] r_lat_addr;
    logic [DATA_WIDTH-1:0] r_lat_wd;
    logic                  r_lat_we;
    logic                  r_owner_d;

    logic w_hi_req;
    logic w_lo_req;
    logic w_lo_win;
    logic w_hi_win;
    logic w_if_win;
    logic w_d_win;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_lo_gnt;
    logic w_mem_we;

    // Raw arbitration: high side wins ties unless the low side has waited STARVE_LIMIT cycles
    always_comb begin
        w_hi_req = D_IS_HI ? d_req : if_req;
        w_lo_req = D_IS_HI ? if_req : d_req;
        w_lo_win = w_lo_req & (~w_hi_req | (r_starve == STARVE_MAX));
        w_hi_win = w_hi_req & ~w_lo_win;
        w_d_win  = D_IS_HI ? w_hi_win : w_lo_win;
        w_if_win = D_IS_HI ? w_lo_win : w_hi_win;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, grants and write strobe; nothing is granted or written during reset
    always_comb begin
        w_state_nxt = S_IDLE;
        w_if_gnt    = 1'b0;
        w_d_gnt     = 1'b0;
        w_mem_we    = 1'b0;
        if (!RST) begin
            w_if_gnt = w_if_win;
            w_d_gnt  = w_d_win;
            if (w_if_win || w_d_win) begin
                w_state_nxt = S_ACC;
            end
            w_mem_we = (r_state == S_ACC) & r_owner_d & r_lat_we;
        end
    end

    assign w_lo_gnt = D_IS_HI ? w_if_gnt : w_d_gnt;

    // Consecutive-denial counter for the low-priority requester, saturating
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_starve <= '0;
        end else if (w_lo_gnt) begin
            r_starve <= '0;
        end else if (w_lo_req && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Latch the winning request; IF accesses are always reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lat_addr <= '0;
            r_lat_wd   <= '0;
            r_lat_we   <= 1'b0;
            r_owner_d  <= 1'b0;
        end else if (w_d_gnt) begin
            r_lat_addr <= d_addr;
            r_lat_wd   <= d_wd;
            r_lat_we   <= d_we;
            r_owner_d  <= 1'b1;
        end else if (w_if_gnt) begin
            r_lat_addr <= if_addr;
            r_lat_wd   <= '0;
            r_lat_we   <= 1'b0;
            r_owner_d  <= 1'b0;
        end
    end

    // Capture read data (read-first for stores) into the owner's response register
    always_ff @(posedge CLK) begin
        if (RST) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= (r_state == S_ACC) & ~r_owner_d;
            d_rvalid  <= (r_state == S_ACC) & r_owner_d;
            if (r_state == S_ACC) begin
                if (r_owner_d) begin
                    d_rdata <= mem_rd;
                end else begin
                    if_rdata <= mem_rd;
                end
            end
        end
    end

    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;
    assign mem_we   = w_mem_we;
    assign mem_addr = DATA_WIDTH'(r_lat_addr);
    assign mem_wd   = r_lat_wd;
    assign busy     = (r_state == S_ACC);

endmodule

// File: tb/tb_idmem_port_arbiter.sv
// Bench for idmem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, latency and memory contents.
module tb_idmem_port_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned SL = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wd;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          busy;

    logic [DW-1:0] mem [64];
    logic          tb_mem_init = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    idmem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .D_PRIORITY  (1),
        .STARVE_LIMIT(SL)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wd     (d_wd),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    // Memory: combinational read-first, write on the clock edge; mem[i] = i after init
    always @(posedge CLK) begin
        if (tb_mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= DW'(i);
        end else if (mem_we) begin
            mem[mem_addr[AW-1:0]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_addr[AW-1:0]];

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wd = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1; tb_mem_init = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0; tb_mem_init = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1; tb_mem_init = 1'b1;
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        @(negedge CLK); #1;
        n_checks++;
        if ({if_gnt, d_gnt, mem_we} !== 3'b000) $display("FAIL reset_gnt got %b expected 000", {if_gnt, d_gnt, mem_we});
        else n_pass++;
        @(negedge CLK);
        idle_inputs(); RST = 1'b0; tb_mem_init = 1'b0; #1;
        n_checks++;
        if ({if_rvalid, d_rvalid, busy} !== 3'b000) $display("FAIL reset_flags got %b expected 000", {if_rvalid, d_rvalid, busy});
        else n_pass++;
        n_checks++;
        if ({if_rdata, d_rdata, mem_addr, mem_wd} !== '0) $display("FAIL reset_data got %h/%h/%h/%h expected 0", if_rdata, d_rdata, mem_addr, mem_wd);
        else n_pass++;
    endtask

    task automatic test_if_read();
        do_reset();
        if_req = 1'b1; if_addr = 6'd15; #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b10) $display("FAIL if_read_gnt got %b expected 10", {if_gnt, d_gnt});
        else n_pass++;
        @(negedge CLK); if_req = 1'b0; #1;
        n_checks++;
        if ({busy, mem_we, if_rvalid} !== 3'b100 || mem_addr !== 32'd15) $display("FAIL if_read_acc got busy/we/rv=%b addr=%h expected 100 addr=0000000f", {busy, mem_we, if_rvalid}, mem_addr);
        else n_pass++;
        @(negedge CLK); #1;
        n_checks++;
        if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'd15) $display("FAIL if_read_resp got rv=%b data=%h expected 10 data=0000000f", {if_rvalid, d_rvalid}, if_rdata);
        else n_pass++;
        @(negedge CLK); #1;
        n_checks++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'd15) $display("FAIL if_read_hold got rv=%b data=%h expected 0 data=0000000f", if_rvalid, if_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3; d_wd = 32'hDEADBEEF; #1;
        n_checks++;
        if ({if_gnt, d_gnt, mem_we} !== 3'b010) $display("FAIL b2b_store_gnt got %b expected 010", {if_gnt, d_gnt, mem_we});
        else n_pass++;
        @(negedge CLK); d_we = 1'b0; d_wd = '0; #1;
        n_checks++;
        if ({d_gnt, mem_we} !== 2'b11 || mem_addr !== 32'd3 || mem_wd !== 32'hDEADBEEF) $display("FAIL b2b_store_acc got gnt/we=%b addr=%h wd=%h expected 11 00000003 deadbeef", {d_gnt, mem_we}, mem_addr, mem_wd);
        else n_pass++;
        @(negedge CLK); d_req = 1'b0; #1;
        n_checks++;
        if ({mem_we, d_rvalid} !== 2'b01 || d_rdata !== 32'd3) $display("FAIL b2b_store_ack got we/rv=%b data=%h expected 01 00000003", {mem_we, d_rvalid}, d_rdata);
        else n_pass++;
        @(negedge CLK); #1;
        n_checks++;
        if ({mem_we, d_rvalid} !== 2'b01 || d_rdata !== 32'hDEADBEEF) $display("FAIL b2b_load got we/rv=%b data=%h expected 01 deadbeef", {mem_we, d_rvalid}, d_rdata);
        else n_pass++;
        @(negedge CLK); #1;
        n_checks++;
        if (d_rvalid !== 1'b0 || mem[3] !== 32'hDEADBEEF) $display("FAIL b2b_after got rv=%b mem3=%h expected 0 deadbeef", d_rvalid, mem[3]);
        else n_pass++;
    endtask

    task automatic test_starvation();
        logic [7:0] pat;
        pat = 8'b0111_0111;
        do_reset();
        if_req = 1'b1; if_addr = 6'd20; d_req = 1'b1; d_we = 1'b0; d_addr = 6'd40;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if ({if_gnt, d_gnt} !== {~pat[k], pat[k]}) $display("FAIL starve_gnt[%0d] got if/d=%b expected %b", k, {if_gnt, d_gnt}, {~pat[k], pat[k]});
            else n_pass++;
            @(negedge CLK);
        end
        idle_inputs();
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset_mid_acc();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd5; d_wd = 32'h12345678; #1;
        n_checks++;
        if (d_gnt !== 1'b1) $display("FAIL rstacc_gnt got %b expected 1", d_gnt);
        else n_pass++;
        @(negedge CLK); idle_inputs(); RST = 1'b1; #1;
        n_checks++;
        if ({mem_we, if_gnt, d_gnt} !== 3'b000) $display("FAIL rstacc_we got we/gnt=%b expected 000", {mem_we, if_gnt, d_gnt});
        else n_pass++;
        @(negedge CLK); RST = 1'b0; #1;
        n_checks++;
        if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, busy} !== 6'b0 || {if_rdata, d_rdata, mem_addr, mem_wd} !== '0)
            $display("FAIL rstacc_outs got flags=%b data=%h/%h/%h/%h expected all 0", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, busy}, if_rdata, d_rdata, mem_addr, mem_wd);
        else n_pass++;
        n_checks++;
        if (mem[5] !== 32'd5) $display("FAIL rstacc_mem got %h expected 00000005", mem[5]);
        else n_pass++;
        @(negedge CLK);
    endtask

    typedef struct {
        int            due;
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } acc_t;

    task automatic test_random();
        acc_t          q[$];
        acc_t          e;
        logic [DW-1:0] model_mem [64];
        logic [DW-1:0] last_if, last_d;
        bit            if_p, d_p, dwe, exp_if_rv, exp_d_rv, exp_if_g, exp_d_g, exp_we, exp_busy;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dwd;
        int            if_denied;
        for (int i = 0; i < 64; i++) model_mem[i] = DW'(i);
        last_if = '0; last_d = '0; if_denied = 0;
        if_p = 1'b0; d_p = 1'b0; ia = '0; da = '0; dwe = 1'b0; dwd = '0;
        do_reset();
        for (int k = 0; k < 1004; k++) begin
            if (k < 1000) begin
                if (!if_p && ($urandom % 4 != 0)) begin if_p = 1'b1; ia = AW'($urandom); end
                else if (if_p && ($urandom % 16 == 0)) if_p = 1'b0;
                if (!d_p && ($urandom % 3 != 0)) begin d_p = 1'b1; da = AW'($urandom); dwe = 1'($urandom); dwd = $urandom; end
                else if (d_p && ($urandom % 16 == 0)) d_p = 1'b0;
            end else begin
                if_p = 1'b0; d_p = 1'b0;
            end
            if_req = if_p; if_addr = ia; d_req = d_p; d_we = dwe; d_addr = da; d_wd = dwd;
            #1;
            // responses completing this cycle, applied to the model memory in order
            exp_if_rv = 1'b0; exp_d_rv = 1'b0;
            if (q.size() > 0 && q[0].due == k) begin
                e = q.pop_front();
                if (e.is_d) begin
                    exp_d_rv = 1'b1; last_d = model_mem[e.addr];
                    if (e.we) model_mem[e.addr] = e.wd;
                end else begin
                    exp_if_rv = 1'b1; last_if = model_mem[e.addr];
                end
            end
            n_checks++;
            if ({if_rvalid, d_rvalid} !== {exp_if_rv, exp_d_rv}) $display("FAIL rnd_rvalid@%0d got %b expected %b", k, {if_rvalid, d_rvalid}, {exp_if_rv, exp_d_rv});
            else n_pass++;
            n_checks++;
            if (if_rdata !== last_if || d_rdata !== last_d) $display("FAIL rnd_rdata@%0d got %h/%h expected %h/%h", k, if_rdata, d_rdata, last_if, last_d);
            else n_pass++;
            // D has priority; IF is forced after SL consecutive denials
            if (if_p && d_p) begin
                exp_if_g = (if_denied == SL); exp_d_g = ~exp_if_g;
            end else begin
                exp_if_g = if_p; exp_d_g = d_p;
            end
            n_checks++;
            if ({if_gnt, d_gnt} !== {exp_if_g, exp_d_g}) $display("FAIL rnd_gnt@%0d got %b expected %b", k, {if_gnt, d_gnt}, {exp_if_g, exp_d_g});
            else n_pass++;
            exp_busy = (q.size() > 0 && q[0].due == k + 1);
            exp_we   = exp_busy && q[0].is_d && q[0].we;
            n_checks++;
            if ({busy, mem_we} !== {exp_busy, exp_we} || (exp_busy && mem_addr !== DW'(q[0].addr)))
                $display("FAIL rnd_mem@%0d got busy/we=%b addr=%h expected %b addr=%h", k, {busy, mem_we}, mem_addr, {exp_busy, exp_we}, exp_busy ? DW'(q[0].addr) : mem_addr);
            else n_pass++;
            if (exp_d_g) q.push_back('{due: k + 2, is_d: 1'b1, we: dwe, addr: da, wd: dwd});
            if (exp_if_g) q.push_back('{due: k + 2, is_d: 1'b0, we: 1'b0, addr: ia, wd: '0});
            if (exp_if_g) if_denied = 0;
            else if (if_p && if_denied < SL) if_denied++;
            if (exp_if_g) if_p = 1'b0;
            if (exp_d_g) d_p = 1'b0;
            @(negedge CLK);
        end
        n_checks++;
        if (q.size() != 0) $display("FAIL rnd_drain got %0d pending expected 0", q.size());
        else n_pass++;
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (mem[i] !== model_mem[i]) $display("FAIL rnd_memfinal[%0d] got %h expected %h", i, mem[i], model_mem[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_back_to_back();
        test_starvation();
        test_reset_mid_acc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
